// File: rtl/avl_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avl_timer_pkg
// Purpose  : Shared register offsets, bit positions and widths for the
//            multi-channel Avalon-MM interval timer.
// Revision : 1.0 - initial release
// ============================================================================
package avl_timer_pkg;

  // Per-channel register offsets (address[1:0])
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  // STATUS bit positions
  localparam int STS_TO  = 0;
  localparam int STS_RUN = 1;

  // CONTROL bit positions
  localparam int CTRL_ITO       = 0;
  localparam int CTRL_CONT      = 1;
  localparam int CTRL_START     = 2;
  localparam int CTRL_STOP      = 3;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_MSB = 15;
  localparam int CTRL_W         = 16;

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module   : timer_channel
// Purpose  : One interval-timer channel: down-counter, period, snapshot,
//            TO/RUN status, control bits and optional 8-bit prescaler.
// Config   : TIMER_PRESCALE_EN - adds the per-channel prescaler and stores
//            CONTROL[15:8]; otherwise the counter ticks every clock.
// Ports    : clk, reset_n      clock, async active-low reset
//            i_wr_status      write strobe for STATUS (clears TO)
//            i_wr_ctrl        write strobe for CONTROL
//            i_wr_period      write strobe for PERIOD
//            i_wr_snap        write strobe for SNAP (latches counter)
//            i_wdata[31:0]    write data
//            i_reg[1:0]       register selected for readback
//            o_rdata[31:0]    combinational readback of i_reg
//            o_irq            TO & ITO
// Revision : 1.0 - initial release
// ============================================================================
module timer_channel
  import avl_timer_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] DEF_PERIOD = 32'd49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_wr_status,
  input  logic        i_wr_ctrl,
  input  logic        i_wr_period,
  input  logic        i_wr_snap,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_reg,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  localparam logic [CNT_W-1:0] C_DEF_PERIOD = DEF_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_snap;
  logic              r_to;
  logic              r_run;
  logic              r_ito;
  logic              r_cont;
  logic              r_force_reload;
  logic              w_tick;
  logic              w_start;
  logic              w_stop;
  logic [CTRL_W-1:0] w_ctrl_rd;

  assign w_start = i_wr_ctrl & i_wdata[CTRL_START];
  assign w_stop  = i_wr_ctrl & i_wdata[CTRL_STOP];

`ifdef TIMER_PRESCALE_EN
  logic [7:0] r_presc;
  logic [7:0] r_presc_cnt;

  // Tick fires when the prescaler hits zero; it then reloads from PRESC,
  // giving one counter step every PRESC+1 clocks.
  assign w_tick = (r_presc_cnt == 8'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc     <= 8'd0;
      r_presc_cnt <= 8'd0;
    end else begin
      if (i_wr_ctrl)
        r_presc <= i_wdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
      if (w_start || i_wr_period)
        r_presc_cnt <= 8'd0;
      else if (r_run) begin
        if (w_tick)
          r_presc_cnt <= r_presc;
        else
          r_presc_cnt <= r_presc_cnt - 8'd1;
      end
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Assignment order below encodes priorities: a timeout set overrides a
  // STATUS clear, and a CONTROL/PERIOD write overrides the one-shot RUN clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt          <= C_DEF_PERIOD;
      r_period       <= C_DEF_PERIOD;
      r_snap         <= '0;
      r_to           <= 1'b0;
      r_run          <= 1'b0;
      r_ito          <= 1'b0;
      r_cont         <= 1'b0;
      r_force_reload <= 1'b0;
    end else begin
      r_force_reload <= i_wr_period;

      if (i_wr_snap)
        r_snap <= r_cnt;

      if (i_wr_status)
        r_to <= 1'b0;

      if (r_force_reload)
        r_cnt <= r_period;
      else if (r_run && w_tick) begin
        if (r_cnt != '0)
          r_cnt <= r_cnt - CNT_W'(1);
        else begin
          r_cnt <= r_period;
          r_to  <= 1'b1;
          if (!r_cont)
            r_run <= 1'b0;
        end
      end

      if (i_wr_ctrl) begin
        r_ito  <= i_wdata[CTRL_ITO];
        r_cont <= i_wdata[CTRL_CONT];
        if (w_start)
          r_run <= 1'b1;
        else if (w_stop)
          r_run <= 1'b0;
      end

      if (i_wr_period) begin
        r_period <= i_wdata[CNT_W-1:0];
        r_run    <= 1'b0;
      end
    end
  end

  // START/STOP are strobes and always read back as 0.
  always_comb begin
    w_ctrl_rd           = '0;
    w_ctrl_rd[CTRL_ITO]  = r_ito;
    w_ctrl_rd[CTRL_CONT] = r_cont;
`ifdef TIMER_PRESCALE_EN
    w_ctrl_rd[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = r_presc;
`endif
  end

  always_comb begin
    o_rdata = '0;
    case (i_reg)
      REG_STATUS: begin
        o_rdata[STS_TO]  = r_to;
        o_rdata[STS_RUN] = r_run;
      end
      REG_CONTROL: o_rdata[CTRL_W-1:0] = w_ctrl_rd;
      REG_PERIOD:  o_rdata[CNT_W-1:0]  = r_period;
      REG_SNAP:    o_rdata[CNT_W-1:0]  = r_snap;
      default:     o_rdata = '0;
    endcase
  end

  assign o_irq = r_to & r_ito;

endmodule
`default_nettype wire

// File: rtl/avl_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : avl_multi_timer
// Purpose  : Multi-channel Avalon-MM interval timer. NUM_CH independent
//            down-counters, each with STATUS/CONTROL/PERIOD/SNAP registers;
//            per-channel interrupts ORed onto irq.
// Config   : TIMER_PRESCALE_EN - enables the per-channel 8-bit prescaler.
// Ports    : clk, reset_n           clock, async active-low reset
//            address[$clog2(NUM_CH)+1:0]  word address {channel, reg}
//            chipselect, write_n   slave select, active-low write
//            writedata[31:0]       write data
//            readdata[31:0]        registered read data (1-cycle latency)
//            irq                   OR of irq_vec
//            irq_vec[NUM_CH-1:0]   per-channel TO & ITO
// Revision : 1.0 - initial release
// ============================================================================
module avl_multi_timer
  import avl_timer_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] DEF_PERIOD = 32'd49999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [$clog2(NUM_CH)+1:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq,
  output logic [NUM_CH-1:0]         irq_vec
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0] w_ch;
  logic [1:0]      w_reg;
  logic            w_wr;
  logic [31:0]     w_rd [NUM_CH];
  logic [31:0]     w_rdata;

  assign w_reg = address[1:0];
  assign w_wr  = chipselect & ~write_n;

  generate
    if (NUM_CH > 1) begin : g_ch_multi
      assign w_ch = address[$clog2(NUM_CH)+1:2];
    end else begin : g_ch_single
      assign w_ch = 1'b0;
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic w_sel;
      assign w_sel = w_wr & (w_ch == CH_W'(i));

      timer_channel #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD)
      ) u_ch (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_wr_status (w_sel & (w_reg == REG_STATUS)),
        .i_wr_ctrl   (w_sel & (w_reg == REG_CONTROL)),
        .i_wr_period (w_sel & (w_reg == REG_PERIOD)),
        .i_wr_snap   (w_sel & (w_reg == REG_SNAP)),
        .i_wdata     (writedata),
        .i_reg       (w_reg),
        .o_rdata     (w_rd[i]),
        .o_irq       (irq_vec[i])
      );
    end
  endgenerate

  // Channel indices beyond NUM_CH (non-power-of-two counts) read as 0.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == CH_W'(i))
        w_rdata = w_rd[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= w_rdata;
  end

  assign irq = |irq_vec;

endmodule
`default_nettype wire
